// File: rtl/mcp_arbiter.sv
// mcp_arbiter: round-robin scheduler sharing one multi-cycle-path CDC channel.
// Optional acknowledge watchdog is compiled in with `define MCP_ARBITER_TIMEOUT_EN.
module mcp_arbiter #(
   parameter int NREQ    = 4,
   parameter int SIZE    = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*SIZE-1:0]    req_data,
   output logic [NREQ-1:0]         req_grant,
   output logic [NREQ-1:0]         req_done,
   output logic [SIZE-1:0]         mcp_data,
   output logic                    mcp_rdy,
   input  logic                    mcp_ack,
   output logic                    mcp_busy,
   output logic [$clog2(NREQ)-1:0] mcp_src,
   output logic                    timeout_err
);
   localparam int SW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

   state_t          state;
   logic [SW-1:0]   last;
   logic [SW-1:0]   win;
   logic            any;
   logic            grant_ok;
   logic [SIZE-1:0] word [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_word
      assign word[g] = req_data[g*SIZE +: SIZE];
   end

   function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] idx);
      logic [NREQ-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
      return SW'((int'(base) + k) % NREQ);
   endfunction

   // First valid requester strictly after the last owner, wrapping.
   always_comb begin
      win = last;
      any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any && req_valid[rr_idx(last, k)]) begin
            win = rr_idx(last, k);
            any = 1'b1;
         end
      end
   end

`ifdef MCP_ARBITER_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
   logic [CW-1:0] cnt;
   logic          ack_hold;
   logic          to_hit;

   assign to_hit   = (cnt == CW'(TIMEOUT - 1));
   // After an abort the channel may still be mid-handshake; hold off until ack is low.
   assign grant_ok = !ack_hold || !mcp_ack;
`else
   assign grant_ok    = 1'b1;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= SW'(NREQ - 1);
         req_grant <= '0;
         req_done  <= '0;
         mcp_rdy   <= 1'b0;
         mcp_busy  <= 1'b0;
         mcp_data  <= '0;
         mcp_src   <= '0;
`ifdef MCP_ARBITER_TIMEOUT_EN
         cnt         <= '0;
         ack_hold    <= 1'b0;
         timeout_err <= 1'b0;
`endif
      end else begin
         req_grant <= '0;
         req_done  <= '0;
         mcp_rdy   <= 1'b0;
`ifdef MCP_ARBITER_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef MCP_ARBITER_TIMEOUT_EN
               if (!mcp_ack) ack_hold <= 1'b0;
`endif
               if (any && grant_ok) begin
                  mcp_data  <= word[win];
                  mcp_src   <= win;
                  req_grant <= onehot(win);
                  mcp_busy  <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               mcp_rdy <= 1'b1;
               state   <= WAIT_HI;
`ifdef MCP_ARBITER_TIMEOUT_EN
               cnt     <= '0;
`endif
            end
            WAIT_HI: begin
`ifdef MCP_ARBITER_TIMEOUT_EN
               cnt <= cnt + 1'b1;
               if (to_hit) begin
                  timeout_err <= 1'b1;
                  req_done    <= onehot(mcp_src);
                  mcp_busy    <= 1'b0;
                  last        <= mcp_src;
                  ack_hold    <= 1'b1;
                  state       <= IDLE;
               end else
`endif
               if (mcp_ack) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!mcp_ack) begin
                  req_done <= onehot(mcp_src);
                  mcp_busy <= 1'b0;
                  last     <= mcp_src;
                  state    <= IDLE;
               end
`ifdef MCP_ARBITER_TIMEOUT_EN
               else if (to_hit) begin
                  timeout_err <= 1'b1;
                  req_done    <= onehot(mcp_src);
                  mcp_busy    <= 1'b0;
                  last        <= mcp_src;
                  ack_hold    <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mcp_arbiter.sv
// Bench for mcp_arbiter: transfer-level model checked every cycle plus directed scenarios.
module tb_mcp_arbiter;
   localparam int NREQ = 4;
   localparam int SIZE = 32;
   localparam int TO   = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SIZE-1:0] req_data;
   logic [NREQ-1:0]      req_grant;
   logic [NREQ-1:0]      req_done;
   logic [SIZE-1:0]      mcp_data;
   logic                 mcp_rdy;
   logic                 mcp_ack = 1'b0;
   logic                 mcp_busy;
   logic [1:0]           mcp_src;
   logic                 timeout_err;

   int n_checks = 0;
   int n_err    = 0;

   logic ack_en   = 1'b1;
   int   ack_rise = 5;
   int   ack_hold = 6;

   mcp_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_grant(req_grant), .req_done(req_done), .mcp_data(mcp_data),
      .mcp_rdy(mcp_rdy), .mcp_ack(mcp_ack), .mcp_busy(mcp_busy),
      .mcp_src(mcp_src), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Channel responder: after each mcp_rdy, raise ack after ack_rise cycles, hold ack_hold cycles.
   always begin
      @(negedge clk);
      if (mcp_rdy === 1'b1 && ack_en) begin
         repeat (ack_rise) @(negedge clk);
         mcp_ack = 1'b1;
         repeat (ack_hold) @(negedge clk);
         mcp_ack = 1'b0;
      end
   end

   // Transfer-level model: a transfer has an age in edges since grant, a flag for
   // having seen ack high, and completes on the first low ack after that.
   logic            m_live = 1'b0;
   logic            m_busy, m_hi, m_hold;
   int              m_age, m_last;
   logic [NREQ-1:0] e_grant, e_done;
   logic            e_rdy, e_busy, e_to;
   logic [1:0]      e_src;
   logic [SIZE-1:0] e_data;
`ifdef MCP_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   always @(posedge clk) begin
      e_grant = '0;
      e_done  = '0;
      e_rdy   = 1'b0;
      e_to    = 1'b0;
      if (rst) begin
         m_live = 1'b1;
         m_busy = 1'b0;
         m_hi   = 1'b0;
         m_hold = 1'b0;
         m_age  = 0;
         m_last = NREQ - 1;
         e_busy = 1'b0;
         e_src  = '0;
         e_data = '0;
      end else if (m_live) begin
         if (!m_busy) begin
            if (!mcp_ack) m_hold = 1'b0;
            if (!m_hold) begin
               for (int k = 1; k <= NREQ; k++) begin
                  int c;
                  c = (m_last + k) % NREQ;
                  if (!m_busy && req_valid[c]) begin
                     m_busy     = 1'b1;
                     m_age      = 0;
                     m_hi       = 1'b0;
                     e_grant[c] = 1'b1;
                     e_src      = 2'(c);
                     e_data     = req_data[c*SIZE +: SIZE];
                     e_busy     = 1'b1;
                  end
               end
            end
         end else begin
            m_age++;
            if (m_age == 1) e_rdy = 1'b1;
            else if (m_hi && !mcp_ack) begin
               e_done[e_src] = 1'b1;
               e_busy = 1'b0;
               m_busy = 1'b0;
               m_last = int'(e_src);
            end else if (TO_EN && m_age == TO + 1) begin
               e_done[e_src] = 1'b1;
               e_to   = 1'b1;
               e_busy = 1'b0;
               m_busy = 1'b0;
               m_hold = 1'b1;
               m_last = int'(e_src);
            end else if (mcp_ack) m_hi = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cycle", 64'({req_grant, req_done, mcp_rdy, mcp_busy, timeout_err, mcp_src, mcp_data}),
                        64'({e_grant, e_done, e_rdy, e_busy, e_to, e_src, e_data}));
         if (mcp_rdy === 1'b1) check("rdy_while_ack", 64'(mcp_ack), 64'(0));
      end
   end

   int gq[$];
   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) if (req_grant[i] === 1'b1) gq.push_back(i);
   end

   function automatic logic ev_hit(input int what);
      case (what)
         0:       return req_grant != '0;
         1:       return mcp_rdy === 1'b1;
         2:       return req_done != '0;
         default: return mcp_busy === 1'b0;
      endcase
   endfunction

   task automatic wait_ev(input string name, input int what, input int limit);
      int n;
      n = 0;
      while (!ev_hit(what) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!ev_hit(what)) check(name, 64'(0), 64'(1));
   endtask

   initial begin
      int n, good;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
      repeat (3) @(negedge clk);
      check("reset_out", 64'({req_grant, req_done, mcp_rdy, mcp_busy, timeout_err, mcp_src, mcp_data}), 64'(0));
      rst = 1'b0;

      // Single transfer, ack 5 cycles after rdy, 6 cycles high.
      @(negedge clk);
      req_valid = 4'b0001;
      @(negedge clk);
      check("t1_grant", 64'(req_grant), 64'(4'b0001));
      check("t1_busy", 64'(mcp_busy), 64'(1));
      req_valid = '0;
      @(negedge clk);
      check("t1_rdy", 64'(mcp_rdy), 64'(1));
      n = 0;
      while (req_done == '0 && n < 100) begin
         @(negedge clk);
         n++;
         if (req_done == '0) check("t1_hold", 64'(mcp_data), 64'(32'hA5A5_0001));
      end
      check("t1_done", 64'(req_done), 64'(4'b0001));
      check("t1_latency", 64'(n), 64'(12));

      // All requesters valid from a fresh reset: strict rotation.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ack_rise = 2;
      ack_hold = 3;
      gq.delete();
      req_valid = 4'b1111;
      n = 0;
      while (gq.size() < 5 && n < 300) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      check("t2_count", 64'(gq.size() >= 5), 64'(1));
      if (gq.size() >= 5) begin
         check("t2_g0", 64'(gq[0]), 64'(0));
         check("t2_g1", 64'(gq[1]), 64'(1));
         check("t2_g2", 64'(gq[2]), 64'(2));
         check("t2_g3", 64'(gq[3]), 64'(3));
         check("t2_g4", 64'(gq[4]), 64'(0));
      end
      wait_ev("t2_idle", 3, 100);

      // Requester 2 arrives while requester 1 owns the channel.
      @(negedge clk);
      req_valid = 4'b0010;
      wait_ev("t3_grant1", 0, 20);
      check("t3_grant1v", 64'(req_grant), 64'(4'b0010));
      @(negedge clk);
      req_valid = '0;
      wait_ev("t3_rdy", 1, 20);
      req_valid = 4'b0100;
      n = 0;
      while (req_done == '0 && n < 100) begin
         @(negedge clk);
         n++;
         if (req_done == '0) begin
            check("t3_nogrant", 64'(req_grant), 64'(0));
            check("t3_data", 64'(mcp_data), 64'(32'hA5A5_0002));
         end
      end
      check("t3_done1", 64'(req_done), 64'(4'b0010));
      @(negedge clk);
      check("t3_grant2", 64'(req_grant), 64'(4'b0100));
      check("t3_data2", 64'(mcp_data), 64'(32'hA5A5_0003));
      req_valid = '0;
      wait_ev("t3_idle", 3, 100);

      // Reset while waiting for ack high.
      ack_en = 1'b0;
      @(negedge clk);
      req_valid = 4'b0001;
      wait_ev("t4_grant", 0, 20);
      @(negedge clk);
      req_valid = '0;
      wait_ev("t4_rdy", 1, 20);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t4_reset_out", 64'({req_grant, req_done, mcp_rdy, mcp_busy, timeout_err, mcp_src, mcp_data}), 64'(0));
      rst = 1'b0;
      ack_en = 1'b1;
      req_valid = 4'b1000;
      @(negedge clk);
      check("t4_grant3", 64'(req_grant), 64'(4'b1000));
      check("t4_src3", 64'(mcp_src), 64'(3));
      req_valid = '0;
      wait_ev("t4_done", 2, 100);
      check("t4_done3", 64'(req_done), 64'(4'b1000));
      wait_ev("t4_idle", 3, 20);

      // Ack never arrives.
      ack_en = 1'b0;
      @(negedge clk);
      req_valid = 4'b0001;
      wait_ev("t5_grant", 0, 20);
      @(negedge clk);
      req_valid = '0;
      wait_ev("t5_rdy", 1, 20);
`ifdef MCP_ARBITER_TIMEOUT_EN
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_to_latency", 64'(n), 64'(TO));
      check("t5_to_done", 64'(req_done), 64'(4'b0001));
      @(negedge clk);
      check("t5_idle", 64'(mcp_busy), 64'(0));
`else
      good = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (mcp_busy === 1'b1 && timeout_err === 1'b0) good++;
      end
      check("t5_stuck_busy", 64'(good), 64'(2000));
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not reach its end");
      $fatal(1, "bench time limit");
   end
endmodule
